// File: rtl/repair_arbiter.sv
// repair_arbiter: fixed-priority collector of predictor-repair requests, buffered in a
// circular queue and drained to the BPU repair port over valid/ready.
module repair_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int CKPT_W  = 16,
  parameter int ACT_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_valid_i,
  input  logic [NUM_SRC-1:0]          src_flush_i,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_erroVAddr_i,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_corrDest_i,
  input  logic [NUM_SRC-1:0]          src_corrTake_i,
  input  logic [NUM_SRC*CKPT_W-1:0]   src_checkPoint_i,
  input  logic [NUM_SRC*ACT_W-1:0]    src_repairAction_i,
  output logic                        src_ready_o,
  output logic                        rep_valid_o,
  input  logic                        rep_ready_i,
  output logic [$clog2(NUM_SRC)-1:0]  rep_src_o,
  output logic [ADDR_W-1:0]           rep_erroVAddr_o,
  output logic [ADDR_W-1:0]           rep_corrDest_o,
  output logic                        rep_corrTake_o,
  output logic [CKPT_W-1:0]           rep_checkPoint_o,
  output logic [ACT_W-1:0]            rep_repairAction_o,
  output logic [$clog2(DEPTH):0]      occupancy_o,
  output logic [CNT_W-1:0]            drop_cnt_o
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int PW = $clog2(DEPTH);
  localparam int PL = 2*ADDR_W + 1 + CKPT_W + ACT_W;
  logic [PL-1:0]    pay_q [DEPTH];
  logic [SW-1:0]    src_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic [SW-1:0]    win;
  logic [PL-1:0]    win_pay;
  logic [CNT_W-1:0] n_drop;
  logic [CNT_W:0]   drop_sum;
  logic             any_v, win_flush, full, head_live, pop, push, clear;
  always_comb begin
    win       = '0;
    win_pay   = '0;
    win_flush = 1'b0;
    any_v     = 1'b0;
    n_drop    = '0;
    for (int k = NUM_SRC-1; k >= 0; k--)
      if (src_valid_i[k]) begin
        win       = SW'(k);
        win_flush = src_flush_i[k];
        any_v     = 1'b1;
        n_drop    = n_drop + CNT_W'(1);
        win_pay   = {src_erroVAddr_i[k*ADDR_W +: ADDR_W], src_corrDest_i[k*ADDR_W +: ADDR_W],
                     src_corrTake_i[k], src_checkPoint_i[k*CKPT_W +: CKPT_W],
                     src_repairAction_i[k*ACT_W +: ACT_W]};
      end
    full      = count == (PW+1)'(DEPTH);
    head_live = live_q[rd_ptr];
    pop       = (count != '0) && (rep_ready_i || !head_live);
    push      = any_v && (win_flush || !full);
    clear     = any_v && win_flush && full;
    // losers plus a non-flush winner turned away by a full queue
    n_drop    = n_drop - CNT_W'(any_v) + CNT_W'(any_v && !win_flush && full);
    drop_sum  = {1'b0, drop_cnt_o} + (CNT_W+1)'(n_drop);
  end
  assign src_ready_o = !full;
  assign rep_valid_o = (count != '0) && head_live;
  assign rep_src_o   = src_q[rd_ptr];
  assign occupancy_o = count;
  assign {rep_erroVAddr_o, rep_corrDest_o, rep_corrTake_o, rep_checkPoint_o,
          rep_repairAction_o} = pay_q[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      live_q     <= '0;
      drop_cnt_o <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pay_q[i] <= '0;
        src_q[i] <= '0;
      end
    end else begin
      drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      if (clear) begin
        live_q   <= DEPTH'(1);
        pay_q[0] <= win_pay;
        src_q[0] <= win;
        rd_ptr   <= '0;
        wr_ptr   <= PW'(1);
        count    <= (PW+1)'(1);
      end else begin
        // kill younger entries first so the same-cycle write below survives
        for (int i = 0; i < DEPTH; i++)
          if (any_v && win_flush && src_q[i] > win) live_q[i] <= 1'b0;
        if (push) begin
          live_q[wr_ptr] <= 1'b1;
          pay_q[wr_ptr]  <= win_pay;
          src_q[wr_ptr]  <= win;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
endmodule
